// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage MIPS pipeline: stall/bubble control and forwarding selects.
// Optional macro HAZ_PERF_EN adds a saturating 32-bit stall_cnt output.
module hazard_ctrl #(
    parameter int unsigned TUSE_NONE = 3,
    parameter int unsigned RA_W      = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] ra1D,
    input  logic [RA_W-1:0] ra2D,
    input  logic [RA_W-1:0] waD,
    input  logic [1:0]      resD,
    input  logic [1:0]      tuse1D,
    input  logic [1:0]      tuse2D,
    output logic            stall,
    output logic            flushE,
    output logic [1:0]      fwd1D,
    output logic [1:0]      fwd2D,
    output logic [1:0]      fwd1E,
    output logic [1:0]      fwd2E,
    output logic            fwd2M
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    localparam logic [1:0] RES_NW  = 2'b00;
    localparam logic [1:0] RES_ALU = 2'b01;
    localparam logic [1:0] RES_DM  = 2'b10;

    logic [RA_W-1:0] waE, ra1E, ra2E, waM, ra2M, waW;
    logic [1:0]      resE, tnewE, resM, tnewM, resW;
    logic [1:0]      tnew_entry, tnew_dec;

    // Live producer in a stage whose destination matches the given source index.
    function automatic logic hit(input logic [1:0] res, input logic [RA_W-1:0] wa,
                                 input logic [RA_W-1:0] ra);
        return (res != RES_NW) && (wa != '0) && (wa == ra);
    endfunction

    function automatic logic src_stall(input logic [RA_W-1:0] ra, input logic [1:0] tuse,
                                       input logic hit_e, input logic [1:0] tn_e,
                                       input logic hit_m, input logic [1:0] tn_m);
        return (ra != '0) && (tuse != 2'(TUSE_NONE)) &&
               ((hit_e && (tn_e > tuse)) || (hit_m && (tn_m > tuse)));
    endfunction

    // Nearest matching stage wins; a match that is not ready yet blocks farther stages.
    function automatic logic [1:0] sel_d(input logic hit_e, input logic [1:0] tn_e,
                                         input logic hit_m, input logic [1:0] tn_m,
                                         input logic hit_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (hit_e)      sel = (tn_e == 2'd0) ? 2'b01 : 2'b00;
        else if (hit_m) sel = (tn_m == 2'd0) ? 2'b10 : 2'b00;
        else if (hit_w) sel = 2'b11;
        return sel;
    endfunction

    function automatic logic [1:0] sel_e(input logic hit_m, input logic [1:0] tn_m,
                                         input logic hit_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (hit_m)      sel = (tn_m == 2'd0) ? 2'b10 : 2'b00;
        else if (hit_w) sel = 2'b11;
        return sel;
    endfunction

    always_comb begin
        tnew_entry = 2'd0;
        case (resD)
            RES_ALU: tnew_entry = 2'd1;
            RES_DM:  tnew_entry = 2'd2;
            default: tnew_entry = 2'd0;
        endcase
        tnew_dec = (tnewE == 2'd0) ? 2'd0 : tnewE - 2'd1;
    end

    always_comb begin
        stall = src_stall(ra1D, tuse1D, hit(resE, waE, ra1D), tnewE, hit(resM, waM, ra1D), tnewM)
              | src_stall(ra2D, tuse2D, hit(resE, waE, ra2D), tnewE, hit(resM, waM, ra2D), tnewM);
        flushE = stall;
        fwd1D  = sel_d(hit(resE, waE, ra1D), tnewE, hit(resM, waM, ra1D), tnewM, hit(resW, waW, ra1D));
        fwd2D  = sel_d(hit(resE, waE, ra2D), tnewE, hit(resM, waM, ra2D), tnewM, hit(resW, waW, ra2D));
        fwd1E  = sel_e(hit(resM, waM, ra1E), tnewM, hit(resW, waW, ra1E));
        fwd2E  = sel_e(hit(resM, waM, ra2E), tnewM, hit(resW, waW, ra2E));
        fwd2M  = hit(resW, waW, ra2M);
    end

    // D->E loads a bubble on stall; E->M and M->W always advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waE   <= '0;
            ra1E  <= '0;
            ra2E  <= '0;
            resE  <= RES_NW;
            tnewE <= 2'd0;
            waM   <= '0;
            ra2M  <= '0;
            resM  <= RES_NW;
            tnewM <= 2'd0;
            waW   <= '0;
            resW  <= RES_NW;
        end else begin
            if (stall) begin
                waE   <= '0;
                ra1E  <= '0;
                ra2E  <= '0;
                resE  <= RES_NW;
                tnewE <= 2'd0;
            end else begin
                waE   <= waD;
                ra1E  <= ra1D;
                ra2E  <= ra2D;
                resE  <= resD;
                tnewE <= tnew_entry;
            end
            waM   <= waE;
            ra2M  <= ra2E;
            resM  <= resE;
            tnewM <= tnew_dec;
            waW   <= waM;
            resW  <= resM;
        end
    end

`ifdef HAZ_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= 32'd0;
        else if (stall && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Consumer end of the stage-attribute stream (ra1, ra2, wa, res) that the pipeline registers carry from D to E to M to W.
- Holds its own E/M/W copies of the destination register and result type, and counts down each producer's Tnew.
- Compares them against decode-stage source registers and their Tuse.
- Drives the stall/bubble control and all forwarding-mux selects for the 5-stage MIPS pipeline.

Parameters:
- TUSE_NONE, 3, Tuse code meaning "operand not read"; never causes a stall.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  asynchronous active-low reset.
- ra1D  in  RA_W  rs index of instruction in D.
- ra2D  in  RA_W  rt index of instruction in D.
- waD  in  RA_W  destination index of instruction in D.
- resD  in  2  result type in D: 00 NW (no write), 01 ALU, 10 DM (load), 11 PC (link).
- tuse1D  in  2  cycles until rs is needed (0=D, 1=E, 2=M, TUSE_NONE).
- tuse2D  in  2  same for rt.
- stall  out  1  freeze PC and IF/ID; same cycle as hazard detection.
- flushE  out  1  equals stall; ID/EX outside loads a bubble.
- fwd1D  out  2  D-stage rs mux: 00 RF, 01 E link value, 10 M result, 11 W result.
- fwd2D  out  2  same for rt.
- fwd1E  out  2  E-stage rs mux: 00 ID/EX value, 10 M, 11 W (01 unused).
- fwd2E  out  2  same for rt.
- fwd2M  out  1  M-stage store-data mux: 0 EX/MEM value, 1 W.

Behaviour:
- State registers: waE/resE/tnewE/ra1E/ra2E, waM/resM/tnewM/ra2M, waW/resW. Tnew is 2 bits.
- A producer is live when res≠NW and wa≠0. Register 0 is never stalled on or forwarded.
- Reset: while rst=0, all state registers are 0, asynchronously. Outputs are combinational from state and D inputs, so during reset stall=0, flushE=0 and all fwd=0.
- Tnew on entry to E: ALU 1, DM 2, PC 0, NW 0.
- Tnew on E→M: max(tnewE−1, 0). W has Tnew 0 implicitly.
- Normal clock edge:
  - D attributes → E, with tnewE computed from resD.
  - E attributes → M.
  - M attributes → W.
- Stall edge (stall=1):
  - E registers load all zeros (bubble).
  - M←E and W←M advance normally.
  - D inputs are held externally, so the check re-evaluates next cycle.
- Stall is combinational: stall=1 if, for either source s with ra_sD≠0 and tuse_sD≠TUSE_NONE, either:
  - live E producer with waE==ra_sD and tnewE>tuse_sD; or
  - live M producer with waM==ra_sD and tnewM>tuse_sD.
- Forward priority is nearest stage first. A stage qualifies only if live, its wa matches, and its Tnew is 0.
  - fwdD: E(01) > M(10) > W(11) > RF(00).
  - fwdE: compared against ra1E/ra2E; M(10) > W(11) > 00.
  - fwd2M: compared against ra2M; W(1) > 0.
  - A matching nearer stage with Tnew>0 blocks fallback to a farther stage; the select is 00, and the stall covers it.
- fwd outputs are computed even while stall=1. Consumers ignore them while the bubble is in flight.
- Reset asserted mid-stall clears all stages immediately. The first cycle after release is hazard-free.
- Latency: stall and fwd are valid in the same cycle as their inputs. State is one cycle per stage.

Optional Feature:
- Macro HAZ_PERF_EN.
- Defined:
  - adds output stall_cnt (32 bits), incremented on every posedge with stall=1;
  - cleared by reset;
  - saturates at 0xFFFFFFFF.
- Undefined:
  - port and counter are absent;
  - all other behaviour is identical.

Test Plan:
- Reset, then an ALU producer and a dependent consumer back-to-back:
  - cycle 1: D = addu $3 (resD=01, waD=3);
  - cycle 2: D = addu reading ra1D=3 with tuse1D=1;
  - required: stall=0 in both cycles, and fwd1E=10 on the consumer's E cycle.
- Load-use:
  - cycle 1: D = lw $5 (resD=10, waD=5);
  - cycle 2: consumer with ra2D=5, tuse2D=1;
  - required: stall=1 and flushE=1 for exactly 1 cycle, then fwd2E=11 on the consumer's E cycle.
- Branch after load:
  - cycle 1: D = lw $4 (resD=10, waD=4);
  - cycle 2: D = beq reading ra1D=4, tuse1D=0;
  - required: stall=1 for exactly 2 cycles, then fwd1D=11 on the first unstalled cycle.
- jal then jr $31:
  - cycle 1: D = jal (resD=11, waD=31);
  - cycle 2: D = jr reading ra1D=31, tuse1D=0;
  - required: stall=0 and fwd1D=01 on the jr's D cycle.
- $0 and NW cases:
  - case A: D = producer with resD=01, waD=0; then consumer with ra1D=0, tuse1D=0;
  - case B: D = producer with resD=00, waD=7; then consumer with ra1D=7, tuse1D=0;
  - required in both cases: stall=0 and fwd1D=00.
- Drop rst to 0 while stall=1:
  - required: stall drops to 0 immediately, before any clock edge;
  - required: all fwd outputs read 0;
  - with HAZ_PERF_EN defined, stall_cnt reads 0.
